// File: rtl/sprite_pkg.sv
// Shared sprite constants: field widths, transparent pixel, sprite type codes
// and the in-bounds test used when gating ROM pixels.
package sprite_pkg;

  localparam int unsigned SPR_X_W    = 6;
  localparam int unsigned SPR_Y_W    = 5;
  localparam int unsigned SPR_TYPE_W = 3;
  localparam int unsigned PIX_W      = 12;

  localparam logic [PIX_W-1:0] PIX_TRANSPARENT = 12'h000;

  typedef enum logic [SPR_TYPE_W-1:0] {
    SPR_NONE   = 3'd0,
    SPR_COIN   = 3'd1,
    SPR_SHARK  = 3'd2,
    SPR_SURFER = 3'd3
  } spr_type_e;

  // True when (x,y) lies inside a w x h sprite.
  function automatic logic in_bounds(logic [SPR_X_W-1:0] x, logic [SPR_Y_W-1:0] y,
                                     int unsigned w, int unsigned h);
    return (32'(x) < w) && (32'(y) < h);
  endfunction

endpackage

// File: rtl/sprite_rom_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches ptr+1, ptr+2, ... mod N and
// returns a one-hot grant plus the winner index.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && (i == (32'(ptr) + k) % N) && req[i]) begin
          found  = 1'b1;
          gnt[i] = 1'b1;
          idx    = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/sprite_rom_sched.sv
// Shares one sprite ROM among N_REQ renderers (round-robin, one lookup/clock)
// and owns the global animation frame counter. Optional: SPRITE_SCHED_PAUSE_EN.
module sprite_rom_sched
  import sprite_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned WIDTH      = 40,
  parameter int unsigned HEIGHT     = 20,
  parameter int unsigned LOG_FRAMES = 3,
  parameter int unsigned NUM_FRAMES = 5,
  parameter int unsigned FRAME_DIV  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tick_in,
`ifdef SPRITE_SCHED_PAUSE_EN
  input  logic                        pause_in,
`endif
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*SPR_X_W-1:0]    req_x,
  input  logic [N_REQ*SPR_Y_W-1:0]    req_y,
  input  logic [N_REQ*SPR_TYPE_W-1:0] req_type,
  output logic [N_REQ-1:0]            gnt,
  output logic [SPR_X_W-1:0]          rom_x,
  output logic [SPR_Y_W-1:0]          rom_y,
  output logic [SPR_TYPE_W-1:0]       rom_type,
  output logic [LOG_FRAMES-1:0]       rom_frame,
  input  logic [PIX_W-1:0]            rom_pixel,
  output logic                        pix_valid,
  output logic [2:0]                  pix_id,
  output logic [PIX_W-1:0]            pixel,
  output logic [LOG_FRAMES-1:0]       frame
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      win_idx;
  logic                  pix_valid_q, pix_valid_d;
  logic [2:0]            pix_id_q, pix_id_d;
  logic [PIX_W-1:0]      pixel_q, pixel_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [LOG_FRAMES-1:0] frame_q, frame_d;
  logic                  tick_ok;

  // Requests are masked during reset so no grant is shown while rst_n is low.
  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req (req & {N_REQ{rst_n}}),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (win_idx)
  );

  // One-hot grant makes an OR-mux sufficient; all zero when nothing is granted.
  always_comb begin
    rom_x    = '0;
    rom_y    = '0;
    rom_type = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        rom_x    = rom_x    | req_x[i*SPR_X_W +: SPR_X_W];
        rom_y    = rom_y    | req_y[i*SPR_Y_W +: SPR_Y_W];
        rom_type = rom_type | req_type[i*SPR_TYPE_W +: SPR_TYPE_W];
      end
    end
  end

`ifdef SPRITE_SCHED_PAUSE_EN
  assign tick_ok = tick_in & ~pause_in;
`else
  assign tick_ok = tick_in;
`endif

  always_comb begin
    ptr_d       = ptr_q;
    pix_valid_d = |gnt;
    pix_id_d    = pix_id_q;
    pixel_d     = pixel_q;
    div_d       = div_q;
    frame_d     = frame_q;
    if (|gnt) begin
      ptr_d    = win_idx;
      pix_id_d = 3'(win_idx);
      pixel_d  = in_bounds(rom_x, rom_y, WIDTH, HEIGHT) ? rom_pixel : PIX_TRANSPARENT;
    end
    if (tick_ok) begin
      if (div_q == DIV_W'(FRAME_DIV - 1)) begin
        div_d   = '0;
        frame_d = (frame_q == LOG_FRAMES'(NUM_FRAMES - 1)) ? '0 : frame_q + 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= IDX_W'(N_REQ - 1);
      pix_valid_q <= 1'b0;
      pix_id_q    <= '0;
      pixel_q     <= '0;
      div_q       <= '0;
      frame_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      pix_valid_q <= pix_valid_d;
      pix_id_q    <= pix_id_d;
      pixel_q     <= pixel_d;
      div_q       <= div_d;
      frame_q     <= frame_d;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_id    = pix_id_q;
  assign pixel     = pixel_q;
  assign frame     = frame_q;
  assign rom_frame = frame_q;

endmodule

// File: tb/tb_sprite_rom_sched.sv
// Directed bench for sprite_rom_sched with a result scoreboard and a stand-in ROM.
module tb_sprite_rom_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick_in;
  logic        pause_in;
  logic [3:0]  req;
  logic [23:0] req_x;
  logic [19:0] req_y;
  logic [11:0] req_type;
  logic [3:0]  gnt;
  logic [5:0]  rom_x;
  logic [4:0]  rom_y;
  logic [2:0]  rom_type;
  logic [2:0]  rom_frame;
  logic [11:0] rom_pixel;
  logic        pix_valid;
  logic [2:0]  pix_id;
  logic [11:0] pixel;
  logic [2:0]  frame;

  logic [5:0]  sx [4];
  logic [4:0]  sy [4];
  logic [2:0]  st [4];

  int          n_assert = 0;
  int          n_fail   = 0;
  int          exp_div  = 0;
  logic [2:0]  exp_frame = '0;
  logic [14:0] sb [$];

  always #5 clk = ~clk;

  sprite_rom_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_in   (tick_in),
`ifdef SPRITE_SCHED_PAUSE_EN
    .pause_in  (pause_in),
`endif
    .req       (req),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_type  (req_type),
    .gnt       (gnt),
    .rom_x     (rom_x),
    .rom_y     (rom_y),
    .rom_type  (rom_type),
    .rom_frame (rom_frame),
    .rom_pixel (rom_pixel),
    .pix_valid (pix_valid),
    .pix_id    (pix_id),
    .pixel     (pixel),
    .frame     (frame)
  );

  function automatic logic [11:0] rom_model(logic [5:0] x, logic [4:0] y, logic [2:0] t, logic [2:0] f);
    return {t, f, x} ^ (12'(y) << 7);
  endfunction

  assign rom_pixel = rom_model(rom_x, rom_y, rom_type, rom_frame);
  always_comb begin
    req_x = '0; req_y = '0; req_type = '0;
    for (int i = 0; i < 4; i++) begin
      req_x[i*6 +: 6]    = sx[i];
      req_y[i*5 +: 5]    = sy[i];
      req_type[i*3 +: 3] = st[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check grant/ROM fields now, push expected result, check it after the edge.
  task automatic step(input logic [3:0] exp_gnt, input logic t);
    int w;
    logic [11:0] epix;
    tick_in = t;
    #1;
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    if (exp_gnt != 4'b0000) begin
      w = 0;
      for (int i = 0; i < 4; i++) if (exp_gnt[i]) w = i;
      chk("rom_fields", {13'b0, rom_x, rom_y, rom_type, rom_frame},
          {13'b0, sx[w], sy[w], st[w], exp_frame});
      epix = (sx[w] < 6'd40 && sy[w] < 5'd20) ? rom_model(sx[w], sy[w], st[w], exp_frame) : 12'h000;
      sb.push_back({3'(w), epix});
    end else begin
      chk("rom_idle", {18'b0, rom_x, rom_y, rom_type}, 32'd0);
    end
    @(posedge clk);
    #1;
    tick_in = 1'b0;
    if (t && !pause_in) begin
      if (exp_div == 7) begin
        exp_div   = 0;
        exp_frame = (exp_frame == 3'd4) ? 3'd0 : exp_frame + 3'd1;
      end else begin
        exp_div++;
      end
    end
    chk("frame", 32'(frame), 32'(exp_frame));
    if (sb.size() > 0) begin
      logic [14:0] e;
      e = sb.pop_front();
      chk("pix_valid", 32'(pix_valid), 32'd1);
      chk("pix_id", 32'(pix_id), 32'(e[14:12]));
      chk("pixel", 32'(pixel), 32'(e[11:0]));
    end else begin
      chk("pix_valid_idle", 32'(pix_valid), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; tick_in = 1'b0; pause_in = 1'b0; req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      sx[i] = 6'(3 + 7 * i); sy[i] = 5'(2 + 3 * i); st[i] = 3'(i + 1);
    end
    #12;
    // Reset values, including ticks ignored while in reset.
    tick_in = 1'b1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_outs", {16'b0, pix_valid, pix_id, pixel}, 32'd0);
    chk("rst_frame", {26'b0, frame, rom_frame}, 32'd0);
    @(posedge clk); #1;
    tick_in = 1'b0; req = 4'b0000;
    chk("rst_frame_tick", 32'(frame), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single lookup from requester 0.
    sx[0] = 6'd17; sy[0] = 5'd0; st[0] = 3'd1;
    req = 4'b0001;
    step(4'b0001, 1'b0);

    // All four requesting: fair rotation.
    req = 4'b1111;
    step(4'b0010, 1'b0); step(4'b0100, 1'b0); step(4'b1000, 1'b0); step(4'b0001, 1'b0);
    step(4'b0010, 1'b0); step(4'b0100, 1'b0); step(4'b1000, 1'b0); step(4'b0001, 1'b0);

    // Idle requesters are skipped.
    req = 4'b0101;
    step(4'b0100, 1'b0); step(4'b0001, 1'b0); step(4'b0100, 1'b0);

    // 40 ticks: frame 0->4 then wraps; grants on advancing ticks carry the old frame.
    for (int i = 0; i < 40; i++) begin
      req = (i == 7 || i == 15 || i == 39) ? 4'b0001 : 4'b0000;
      step(req, 1'b1);
    end
    req = 4'b0000;
    chk("frame_wrap", 32'(frame), 32'd0);

    // Out-of-range coordinates are granted but return transparent.
    req = 4'b0010;
    sx[1] = 6'd40; sy[1] = 5'd5;  step(4'b0010, 1'b0);
    sx[1] = 6'd5;  sy[1] = 5'd20; step(4'b0010, 1'b0);
    sx[1] = 6'd39; sy[1] = 5'd19; step(4'b0010, 1'b0);

    // Reach frame 3 with a result in flight, then reset asynchronously.
    req = 4'b0100;
    for (int i = 0; i < 24; i++) step(4'b0100, 1'b1);
    chk("frame_pre_rst", 32'(frame), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(pix_valid), 32'd0);
    chk("rst_async_frame", {26'b0, frame, rom_frame}, 32'd0);
    chk("rst_async_gnt", 32'(gnt), 32'd0);
    sb.delete(); exp_div = 0; exp_frame = '0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    req = 4'b1000;
    step(4'b1000, 1'b0);

    // Second reset: requester 0 has top priority again.
    req = 4'b0000;
    rst_n = 1'b0; #2 rst_n = 1'b1;
    @(posedge clk); #1;
    req = 4'b1111;
    step(4'b0001, 1'b0);
    step(4'b0010, 1'b0);
    req = 4'b0000;
    step(4'b0000, 1'b0);

`ifdef SPRITE_SCHED_PAUSE_EN
    // Paused ticks freeze divider and frame; arbitration keeps running.
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b1);
    pause_in = 1'b1;
    req = 4'b0100;
    for (int i = 0; i < 16; i++) step(4'b0100, 1'b1);
    chk("pause_frame", 32'(frame), 32'd0);
    pause_in = 1'b0;
    req = 4'b0000;
    for (int i = 0; i < 5; i++) step(4'b0000, 1'b1);
    chk("resume_frame", 32'(frame), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
